// File: rtl/display_src_scheduler.sv
// Chooses which display source owns the shared 4-digit FND path: manual stepping,
// timed auto-rotation, and temporary pop-ups when a source posts new data.
module display_src_scheduler #(
  parameter int N_SRC       = 4,
  parameter int DWELL_TICKS = 3000,
  parameter int POPUP_TICKS = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick_1ms,
  input  logic             i_btn_next,
  input  logic             i_auto_en,
  input  logic [N_SRC-1:0] i_src_en,
  input  logic [N_SRC-1:0] i_evt,
  output logic [1:0]       o_sel,
  output logic [N_SRC-1:0] o_sel_onehot,
  output logic             o_popup,
  output logic             o_sel_chg
);

  localparam int CNT_MAX = (DWELL_TICKS > POPUP_TICKS) ? DWELL_TICKS : POPUP_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] POP_LAST   = CNT_W'(POPUP_TICKS - 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_POPUP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [1:0]       saved_sel, saved_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] pop_cnt, pop_nxt;
  logic             sel_chg;

  logic [N_SRC-1:0] en_eff;
  logic [N_SRC-1:0] evt_m;
  logic             evt_hit;
  logic [1:0]       evt_tgt;
  logic             sel_dis;
  logic             restore;
  state_t           mode_nxt;

  // First enabled index after s, searching circularly; lands on s itself only when s is the sole enabled source.
  function automatic logic [1:0] next_src(input logic [1:0] s, input logic [N_SRC-1:0] en);
    logic [1:0] r;
    logic [1:0] idx;
    r = '0;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      idx = s + 2'(k);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [1:0] lowest_set(input logic [N_SRC-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (v[k]) r = 2'(k);
    end
    return r;
  endfunction

  // Watch (bit 0) can never be disabled, so OR-ing it in keeps next_src() total.
  assign en_eff   = i_src_en | N_SRC'(1);
  assign evt_m    = i_evt & en_eff;
  assign evt_hit  = |evt_m;
  assign evt_tgt  = lowest_set(evt_m);
  assign sel_dis  = !en_eff[sel];
  assign mode_nxt = i_auto_en ? ST_AUTO : ST_MANUAL;

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    saved_nxt = saved_sel;
    dwell_nxt = dwell_cnt;
    pop_nxt   = pop_cnt;
    restore   = 1'b0;

    case (state)
      ST_POPUP: begin
        if (sel_dis || i_btn_next) begin
          restore = 1'b1;
        end else if (evt_hit) begin
          sel_nxt = evt_tgt;
          pop_nxt = '0;
        end else if (i_tick_1ms) begin
          if (pop_cnt == POP_LAST) restore = 1'b1;
          else                     pop_nxt = pop_cnt + 1'b1;
        end
        if (restore) begin
          sel_nxt   = saved_sel;
          state_nxt = mode_nxt;
          dwell_nxt = '0;
          pop_nxt   = '0;
        end
      end

      default: begin
        state_nxt = mode_nxt;
        // Dwell only survives while staying in AUTO; entering AUTO always starts a fresh period.
        if (state != ST_AUTO || !i_auto_en) dwell_nxt = '0;
        if (sel_dis || i_btn_next) begin
          sel_nxt   = next_src(sel, en_eff);
          dwell_nxt = '0;
        end else if (evt_hit) begin
          if (evt_tgt != sel) begin
            state_nxt = ST_POPUP;
            saved_nxt = sel;
            sel_nxt   = evt_tgt;
            pop_nxt   = '0;
          end else begin
            dwell_nxt = '0;
          end
        end else if (state == ST_AUTO && i_auto_en && i_tick_1ms) begin
          if (dwell_cnt == DWELL_LAST) begin
            sel_nxt   = next_src(sel, en_eff);
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_MANUAL;
      sel       <= '0;
      saved_sel <= '0;
      dwell_cnt <= '0;
      pop_cnt   <= '0;
      sel_chg   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      saved_sel <= saved_nxt;
      dwell_cnt <= dwell_nxt;
      pop_cnt   <= pop_nxt;
      sel_chg   <= (sel_nxt != sel);
    end
  end

  assign o_sel        = sel;
  assign o_sel_onehot = N_SRC'(1) << sel;
  assign o_popup      = (state == ST_POPUP);
  assign o_sel_chg    = sel_chg;

endmodule

// File: tb/tb_display_src_scheduler.sv
// Directed, table-driven bench for display_src_scheduler with short dwell/pop-up periods.
module tb_display_src_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick_1ms;
  logic       i_btn_next;
  logic       i_auto_en;
  logic [3:0] i_src_en;
  logic [3:0] i_evt;
  logic [1:0] o_sel;
  logic [3:0] o_sel_onehot;
  logic       o_popup;
  logic       o_sel_chg;

  int n_checks = 0;
  int n_err    = 0;

  display_src_scheduler #(
    .N_SRC      (4),
    .DWELL_TICKS(3),
    .POPUP_TICKS(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick_1ms  (i_tick_1ms),
    .i_btn_next  (i_btn_next),
    .i_auto_en   (i_auto_en),
    .i_src_en    (i_src_en),
    .i_evt       (i_evt),
    .o_sel       (o_sel),
    .o_sel_onehot(o_sel_onehot),
    .o_popup     (o_popup),
    .o_sel_chg   (o_sel_chg)
  );

  always #5 clk = ~clk;

  // gap = idle clocks (pulses low) before the active cycle; expected values hold after the active edge.
  typedef struct {
    int         gap;
    logic       auto_en;
    logic [3:0] src_en;
    logic       btn;
    logic [3:0] evt;
    logic       tick;
    logic [1:0] sel;
    logic       popup;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int gap, input logic auto_en, input logic [3:0] src_en,
                              input logic btn, input logic [3:0] evt, input logic tick,
                              input logic [1:0] sel, input logic popup, input logic chg);
    vec_t v;
    v.gap = gap; v.auto_en = auto_en; v.src_en = src_en; v.btn = btn; v.evt = evt;
    v.tick = tick; v.sel = sel; v.popup = popup; v.chg = chg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] sel, input logic popup, input logic chg);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    check({tag, ".sel"},    32'(o_sel),        32'(sel));
    check({tag, ".onehot"}, 32'(o_sel_onehot), 32'(oh));
    check({tag, ".popup"},  32'(o_popup),      32'(popup));
    check({tag, ".chg"},    32'(o_sel_chg),    32'(chg));
  endtask

  task automatic apply(input vec_t v, input string tag);
    i_auto_en  = v.auto_en;
    i_src_en   = v.src_en;
    i_btn_next = 1'b0;
    i_evt      = 4'b0000;
    i_tick_1ms = 1'b0;
    repeat (v.gap) begin
      @(posedge clk); #1;
    end
    i_btn_next = v.btn;
    i_evt      = v.evt;
    i_tick_1ms = v.tick;
    @(posedge clk); #1;
    i_btn_next = 1'b0;
    i_evt      = 4'b0000;
    i_tick_1ms = 1'b0;
    check_outs(tag, v.sel, v.popup, v.chg);
  endtask

  initial begin
    rst        = 1'b0;
    i_tick_1ms = 1'b0;
    i_btn_next = 1'b0;
    i_auto_en  = 1'b0;
    i_src_en   = 4'b1111;
    i_evt      = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;

    // MANUAL stepping, mask 1111
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 0, 4'h0, 0, 2'd1, 0, 0));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd2, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd3, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 0, 4'h0, 0, 2'd0, 0, 0));
    // AUTO, mask 0101: rotation every 3rd tick, button restarts dwell
    vecs.push_back(mk(0, 1, 4'h5, 0, 4'h0, 0, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd2, 0, 1));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd2, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd2, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 1));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(1, 1, 4'h5, 1, 4'h0, 0, 2'd2, 0, 1));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd2, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd2, 0, 0));
    vecs.push_back(mk(3, 1, 4'h5, 0, 4'h0, 1, 2'd0, 0, 1));
    // Pop-up in AUTO with nested event and timer restart
    vecs.push_back(mk(0, 1, 4'hF, 0, 4'h0, 0, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 0, 4'h8, 0, 2'd3, 1, 1));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd3, 1, 0));
    vecs.push_back(mk(1, 1, 4'hF, 0, 4'h4, 0, 2'd2, 1, 1));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd2, 1, 0));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 1));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd1, 0, 1));
    // Back to MANUAL, collisions, button cancels pop-up
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd2, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd3, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h2, 0, 2'd1, 0, 1));
    vecs.push_back(mk(0, 0, 4'hF, 0, 4'h8, 0, 2'd3, 1, 1));
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(3, 0, 4'hF, 0, 4'h0, 1, 2'd1, 0, 0));
    // Mask removes the current source; event on a disabled source is ignored
    vecs.push_back(mk(0, 0, 4'hF, 1, 4'h0, 0, 2'd2, 0, 1));
    vecs.push_back(mk(0, 0, 4'hB, 0, 4'h0, 0, 2'd3, 0, 1));
    vecs.push_back(mk(0, 0, 4'hB, 0, 4'h4, 0, 2'd3, 0, 0));
    // One-source mask in AUTO: expiry lands on the same index, no change strobe
    vecs.push_back(mk(0, 1, 4'h1, 0, 4'h0, 0, 2'd0, 0, 1));
    vecs.push_back(mk(3, 1, 4'h1, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h1, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(3, 1, 4'h1, 0, 4'h0, 1, 2'd0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 0, 4'h2, 0, 2'd1, 1, 1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a pop-up discards it
    i_auto_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs("rst_popup", 2'd0, 1'b0, 1'b0);
    rst = 1'b1;

    // Disabling the pop-up source ends the pop-up and restores the saved view
    apply(mk(0, 0, 4'hF, 0, 4'h4, 0, 2'd2, 1, 1), "dis_pop_enter");
    apply(mk(0, 0, 4'hB, 0, 4'h0, 0, 2'd0, 0, 1), "dis_pop_end");

    // Event on the current source in AUTO restarts the dwell period without a pop-up
    apply(mk(0, 1, 4'hF, 0, 4'h0, 0, 2'd0, 0, 0), "same_auto");
    apply(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0), "same_t1");
    apply(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0), "same_t2");
    apply(mk(0, 1, 4'hF, 0, 4'h1, 0, 2'd0, 0, 0), "same_evt");
    apply(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0), "same_t3");
    apply(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd0, 0, 0), "same_t4");
    apply(mk(3, 1, 4'hF, 0, 4'h0, 1, 2'd1, 0, 1), "same_t5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
